// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word_t, ramstate_t and the default RAM latency.
// Imported by the RAM responder slice.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word RAM, registered read, no reset (block RAM).
// Ports: CLK, we, idx (word index), wdata, rdata (registered, read-first).
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [2**AW];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/ram_responder.sv
// RAM end of the cache/memory port: FREE/BUSY/ACCESS/ERROR handshake.
// Ports: CLK, nRST, ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] CMAX = CW'((LAT == 0) ? 0 : LAT - 1);

    ramstate_t     state;
    logic [CW-1:0] cnt;
    logic          lwr;
    logic [AW-1:0] lidx;
    word_t         lstore;
    word_t         hold;
    word_t         rdata;

    logic          req;
    logic          bad;
    logic          match;
    logic          fire;
    logic [AW-1:0] idx;

    assign req = ramREN ^ ramWEN;
    assign bad = (ramREN & ramWEN) | (|ramaddr[31:AW+2]);
    assign idx = ramaddr[AW+1:2];

    // Store data only distinguishes writes; a read ignores ramstore.
    assign match = (lwr == ramWEN) && (lidx == idx) &&
                   (!lwr || (lstore == ramstore));

    // Edge that enters ACCESS. From BUSY the live request equals the
    // latch (match), so the array can be fed straight from the inputs,
    // which also covers the LAT=0 path where nothing is latched yet.
    assign fire = !bad && req &&
                  ((state == BUSY) ? (match && (cnt == CMAX))
                                   : (LAT == 0));

    ram_array #(.AW(AW)) u_array (
        .CLK   (CLK),
        .we    (fire & ramWEN & nRST),
        .idx   (idx),
        .wdata (ramstore),
        .rdata (rdata)
    );

    // The array read lands in rdata on ACCESS entry; hold keeps it after.
    assign ramload  = (state == ACCESS && !lwr) ? rdata : hold;
    assign ramstate = state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= FREE;
            cnt    <= '0;
            lwr    <= 1'b0;
            lidx   <= '0;
            lstore <= '0;
            hold   <= '0;
        end else begin
            if (state == ACCESS && !lwr) begin
                hold <= rdata;
            end
            if (bad) begin
                state <= ERROR;
                cnt   <= '0;
            end else if (!req) begin
                state <= FREE;
                cnt   <= '0;
            end else if (state != BUSY || !match) begin
                lwr    <= ramWEN;
                lidx   <= idx;
                lstore <= ramstore;
                cnt    <= '0;
                state  <= (state != BUSY && LAT == 0) ? ACCESS : BUSY;
            end else if (cnt == CMAX) begin
                state <= ACCESS;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: LAT=2 and LAT=0 instances.
// Expected read data is queued at request time and popped on ACCESS.
`timescale 1ns/1ps
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT = 2;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      b_REN, b_WEN;
    word_t     b_addr, b_store, b_load;
    ramstate_t b_state;

    int    nrun  = 0;
    int    nfail = 0;
    word_t mdl [int];
    word_t exp_q [$];
    word_t last_load;

    always #5 CLK = ~CLK;

    ram_responder #(.LAT(LAT), .WORDS(4096)) dut (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    ram_responder #(.LAT(0), .WORDS(4096)) dut0 (
        .CLK(CLK), .nRST(nRST),
        .ramREN(b_REN), .ramWEN(b_WEN),
        .ramaddr(b_addr), .ramstore(b_store),
        .ramload(b_load), .ramstate(b_state)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive one request on dut and wait (bounded) for ACCESS.
    task automatic run_xact(input logic w, input word_t a, input word_t d,
                            output int nbusy, output logic hit);
        int k;
        k = int'(a[13:2]);
        ramREN = !w;
        ramWEN = w;
        ramaddr = a;
        ramstore = d;
        if (!w) exp_q.push_back(mdl.exists(k) ? mdl[k] : 32'h0);
        nbusy = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (ramstate == ACCESS) hit = 1'b1;
            else if (ramstate == BUSY) nbusy++;
        end
        if (hit && w) mdl[k] = d;
    endtask

    task automatic test_reset();
        ramstate_t seq [3];
        seq[0] = BUSY;
        seq[1] = BUSY;
        seq[2] = ACCESS;
        nRST = 1'b0;
        ramREN = 1'b1; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
        b_REN = 1'b0; b_WEN = 1'b0; b_addr = '0; b_store = '0;
        repeat (3) step();
        nrun++;
        if (ramstate !== FREE) begin
            nfail++;
            $display("FAIL reset_state got %0d want %0d", ramstate, FREE);
        end
        nrun++;
        if (ramload !== 32'h0) begin
            nfail++;
            $display("FAIL reset_load got %h want 0", ramload);
        end
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            nrun++;
            if (ramstate !== seq[i]) begin
                nfail++;
                $display("FAIL reset_release[%0d] got %0d want %0d",
                         i, ramstate, seq[i]);
            end
        end
        ramREN = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        int nb; logic hit; word_t e;
        run_xact(1'b1, 32'h40, 32'hDEADBEEF, nb, hit);
        nrun++;
        if (!hit || nb != LAT) begin
            nfail++;
            $display("FAIL wr_latency got busy=%0d hit=%0b want %0d",
                     nb, hit, LAT);
        end
        run_xact(1'b0, 32'h40, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || nb != LAT || ramload !== e) begin
            nfail++;
            $display("FAIL rd_40 got %h busy=%0d want %h", ramload, nb, e);
        end
        run_xact(1'b0, 32'h41, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || ramload !== e) begin
            nfail++;
            $display("FAIL rd_41 got %h want %h", ramload, e);
        end
        ramREN = 1'b0;
        step();
        nrun++;
        if (ramstate !== FREE || ramload !== e) begin
            nfail++;
            $display("FAIL load_hold got %h st=%0d want %h FREE",
                     ramload, ramstate, e);
        end
        last_load = e;
    endtask

    task automatic test_back_to_back();
        int nb; logic hit; word_t e;
        run_xact(1'b1, 32'h44, 32'hCAFE0044, nb, hit);
        run_xact(1'b0, 32'h44, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || nb != LAT || ramload !== e) begin
            nfail++;
            $display("FAIL b2b_rd1 got %h busy=%0d want %h", ramload, nb, e);
        end
        run_xact(1'b0, 32'h44, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || nb != LAT || ramload !== e) begin
            nfail++;
            $display("FAIL b2b_rd2 got %h busy=%0d want %h", ramload, nb, e);
        end
        last_load = e;
        ramREN = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int nb; logic hit; word_t e;
        run_xact(1'b1, 32'h80, 32'hA5A5A5A5, nb, hit);
        ramWEN = 1'b0;
        step();
        ramWEN = 1'b1; ramaddr = 32'h80; ramstore = 32'h1234;
        step();
        step();
        ramWEN = 1'b0;
        step();
        nrun++;
        if (ramstate !== FREE) begin
            nfail++;
            $display("FAIL abort_free got %0d want %0d", ramstate, FREE);
        end
        run_xact(1'b0, 32'h80, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || ramload !== e) begin
            nfail++;
            $display("FAIL abort_rd got %h want %h", ramload, e);
        end
        last_load = e;
        ramREN = 1'b0;
        step();
    endtask

    task automatic test_restart();
        int nb; logic hit; word_t e;
        run_xact(1'b1, 32'h100, 32'h11110100, nb, hit);
        run_xact(1'b1, 32'h104, 32'h22220104, nb, hit);
        ramWEN = 1'b0;
        step();
        ramREN = 1'b1; ramaddr = 32'h100;
        step();
        step();
        nrun++;
        if (ramstate !== BUSY) begin
            nfail++;
            $display("FAIL restart_busy got %0d want %0d", ramstate, BUSY);
        end
        run_xact(1'b0, 32'h104, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || nb != LAT || ramload !== e) begin
            nfail++;
            $display("FAIL restart_rd got %h busy=%0d want %h busy=%0d",
                     ramload, nb, e, LAT);
        end
        last_load = e;
        ramREN = 1'b0;
        step();
    endtask

    task automatic test_error();
        int nb; logic hit; word_t e;
        ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h40;
        for (int i = 0; i < 2; i++) begin
            step();
            nrun++;
            if (ramstate !== ERROR || ramload !== last_load) begin
                nfail++;
                $display("FAIL err_both[%0d] got st=%0d ld=%h want %0d %h",
                         i, ramstate, ramload, ERROR, last_load);
            end
        end
        run_xact(1'b0, 32'h40, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || nb != LAT || ramload !== e) begin
            nfail++;
            $display("FAIL err_recover got %h busy=%0d want %h", ramload, nb, e);
        end
        run_xact(1'b1, 32'h0, 32'h0000AAAA, nb, hit);
        ramWEN = 1'b1; ramaddr = 32'h0001_0000; ramstore = 32'hBAD0BAD0;
        step();
        step();
        nrun++;
        if (ramstate !== ERROR) begin
            nfail++;
            $display("FAIL err_range got %0d want %0d", ramstate, ERROR);
        end
        ramWEN = 1'b0;
        step();
        run_xact(1'b0, 32'h0, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || ramload !== e) begin
            nfail++;
            $display("FAIL err_nowrite got %h want %h", ramload, e);
        end
        ramREN = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int nb; logic hit; word_t e;
        run_xact(1'b1, 32'h200, 32'h600D0200, nb, hit);
        ramWEN = 1'b0;
        step();
        ramWEN = 1'b1; ramstore = 32'hDEAD0200;
        step();
        step();
        nRST = 1'b0;
        #2;
        ramWEN = 1'b0;
        nRST = 1'b1;
        step();
        nrun++;
        if (ramstate !== FREE) begin
            nfail++;
            $display("FAIL midrst_free got %0d want %0d", ramstate, FREE);
        end
        run_xact(1'b0, 32'h200, 32'h0, nb, hit);
        e = exp_q.pop_front();
        nrun++;
        if (!hit || ramload !== e) begin
            nfail++;
            $display("FAIL midrst_rd got %h want %h", ramload, e);
        end
        ramREN = 1'b0;
        step();
    endtask

    task automatic test_lat0();
        word_t a [3];
        word_t e;
        a[0] = 32'h0; a[1] = 32'h4; a[2] = 32'h8;
        b_WEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_addr = a[i];
            b_store = 32'h5A000000 | (i * 32'h111);
            step();
            mdl[1000 + i] = b_store;
            nrun++;
            if (b_state !== ACCESS) begin
                nfail++;
                $display("FAIL lat0_wr[%0d] got %0d want %0d",
                         i, b_state, ACCESS);
            end
        end
        b_WEN = 1'b0;
        b_REN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_addr = a[i];
            exp_q.push_back(mdl[1000 + i]);
            step();
            e = exp_q.pop_front();
            nrun++;
            if (b_state !== ACCESS || b_load !== e) begin
                nfail++;
                $display("FAIL lat0_rd[%0d] got st=%0d ld=%h want %0d %h",
                         i, b_state, b_load, ACCESS, e);
            end
        end
        b_REN = 1'b0;
        step();
        nrun++;
        if (b_state !== FREE || b_load !== e) begin
            nfail++;
            $display("FAIL lat0_free got st=%0d ld=%h want %0d %h",
                     b_state, b_load, FREE, e);
        end
    endtask

    initial begin
        last_load = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_abort();
        test_restart();
        test_error();
        test_reset_mid();
        test_lat0();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
